// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the single-issue ALU datapath.
// Optional build macro SINGLE_STEP_EN adds a step input and a PAUSE state after each writeback.
module core_sequencer #(
  parameter int                   PC_WIDTH   = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0,
  parameter int                   CNT_WIDTH  = 16,
  parameter logic [31:0]          HALT_INSTR = 32'h00000073
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef SINGLE_STEP_EN
  input  logic                 step,
`endif
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [31:0]          imem_rdata,
  input  logic                 imem_valid,
  output logic [31:0]          instr,
  input  logic                 dec_reg_write,
  output logic                 rf_we,
  output logic                 busy,
  output logic                 halted,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [2:0]           state
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;
`ifdef SINGLE_STEP_EN
  localparam logic [2:0] S_PAUSE     = 3'd6;
`endif

  logic [2:0]           state_reg;
  logic [2:0]           state_next;
  logic [PC_WIDTH-1:0]  pc_reg;
  logic [31:0]          instr_reg;
  logic [CNT_WIDTH-1:0] retired_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (start) state_next = S_FETCH;
      S_FETCH:     if (imem_valid) state_next = S_DECODE;
      S_DECODE:    state_next = (instr_reg == HALT_INSTR) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_next = S_WRITEBACK;
`ifdef SINGLE_STEP_EN
      S_WRITEBACK: state_next = S_PAUSE;
      S_PAUSE:     if (step) state_next = S_FETCH;
`else
      S_WRITEBACK: state_next = S_FETCH;
`endif
      S_HALT:      if (start) state_next = S_FETCH;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      pc_reg      <= RESET_PC;
      instr_reg   <= 32'h00000000;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_FETCH && imem_valid)
        instr_reg <= imem_rdata;
      if (state_reg == S_WRITEBACK) begin
        pc_reg <= pc_reg + PC_WIDTH'(4);
        // Counter saturates rather than wrapping.
        if (!(&retired_reg))
          retired_reg <= retired_reg + 1'b1;
      end
      // Restart from HALT rewinds the program but keeps the last instruction word.
      if (state_reg == S_HALT && start) begin
        pc_reg      <= RESET_PC;
        retired_reg <= '0;
      end
    end
  end

  assign imem_req  = (state_reg == S_FETCH);
  assign imem_addr = pc_reg;
  assign instr     = instr_reg;
  assign rf_we     = (state_reg == S_WRITEBACK) && dec_reg_write;
  assign busy      = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                     (state_reg == S_EXECUTE) || (state_reg == S_WRITEBACK);
  assign halted    = (state_reg == S_HALT);
  assign pc        = pc_reg;
  assign retired   = retired_reg;
  assign state     = state_reg;

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the single-issue ALU datapath.
- Fetches 32-bit instructions from instruction memory over a valid-qualified read interface.
- Holds each fetched word in an instruction register that drives the combinational instruction decoder.
- Sequences decode, execute and writeback, and gates the register-file write enable with the decoder's reg_write.
- Maintains the PC, a retired-instruction counter and halt status.

Parameters:
PC_WIDTH, 8, PC and instruction-memory byte-address width; PC wraps modulo 2^PC_WIDTH
RESET_PC, 0, PC value after reset and after restart from HALT
CNT_WIDTH, 16, retired-instruction counter width
HALT_INSTR, 32'h00000073, instruction word that halts the sequencer

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle pulse; leaves IDLE or HALT
imem_req  output  1  read request; high throughout FETCH
imem_addr  output  PC_WIDTH  byte address; equals pc
imem_rdata  input  32  instruction word; valid when imem_valid=1
imem_valid  input  1  read data valid; sampled only in FETCH
instr  output  32  instruction register; feeds decoder
dec_reg_write  input  1  decoder reg_write for the current instr
rf_we  output  1  register-file write strobe
busy  output  1  high in FETCH, DECODE, EXECUTE, WRITEBACK
halted  output  1  high in HALT
pc  output  PC_WIDTH  current program counter
retired  output  CNT_WIDTH  retired-instruction count
state  output  3  encoded state, for debug

Behaviour:
- Reset (async, immediate, any state including mid-instruction) forces these values:
  - state=IDLE, pc=RESET_PC, instr=32'h00000000, retired=0.
  - imem_req=0, rf_we=0, busy=0, halted=0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5. Codes 6 and 7 go to IDLE.
- IDLE: start=1 -> FETCH. Otherwise stay in IDLE.
- FETCH:
  - imem_req=1.
  - imem_valid=0 -> stay in FETCH, with unlimited wait states.
  - imem_valid=1 -> load imem_rdata into instr at that edge, then go to DECODE.
- DECODE:
  - instr==HALT_INSTR -> HALT. pc and retired are not updated, and rf_we stays 0.
  - Otherwise -> EXECUTE.
- EXECUTE: one cycle for ALU settle, then -> WRITEBACK.
- WRITEBACK:
  - rf_we=dec_reg_write, combinational, for exactly this one cycle.
  - At the exit edge: pc<=pc+4 (wraps to 0 past 2^PC_WIDTH-4), retired<=retired+1 (saturates at all-ones), then -> FETCH.
- NOOP words (32'h0, 32'h00000013) take the full path and increment retired. The decoder holds reg_write=0 for them, so rf_we stays 0.
- HALT: halted=1. start=1 -> FETCH with pc<=RESET_PC, retired<=0 and instr held.
- start is ignored while busy=1.
- Minimum latency is 4 cycles per instruction (imem_valid high in the first FETCH cycle). Each FETCH wait cycle adds one.
- rf_we is never asserted outside WRITEBACK.
- imem_valid outside FETCH is ignored.

Optional Feature:
SINGLE_STEP_EN
- Defined:
  - Adds input step (1 bit).
  - WRITEBACK exits to a PAUSE state (code 6) instead of FETCH, with busy=0 and halted=0.
  - In PAUSE, step=1 -> FETCH and start is ignored. Exactly one instruction retires per step pulse.
  - The step input is sampled only in PAUSE.
- Not defined:
  - No step port.
  - Code 6 is illegal and goes to IDLE.
  - Continuous execution as described above.

Test Plan:
- Zero-wait program ADDI, ADD, SUB, HALT_INSTR with imem_valid tied 1, after start -> rf_we pulses once in each of 3 WRITEBACK cycles, 4 cycles apart; halted=1; pc=12; retired=3.
- imem_valid held low 5 cycles on the first fetch -> imem_req high 6 cycles, instr unchanged until the valid edge, retired=1 after 9 cycles total.
- NOOP 32'h00000013 then HALT_INSTR -> rf_we never asserted, retired=1, pc=4.
- PC_WIDTH=8, RESET_PC=252, fetch ADDI then HALT_INSTR -> pc wraps 252->0, HALT fetched from address 0.
- rst asserted in EXECUTE -> state, pc, instr, retired and all outputs return to reset values in the same cycle with no rf_we pulse; start after release refetches from RESET_PC.
- In HALT, pulse start -> FETCH next cycle, pc=RESET_PC, retired=0; a start pulse while busy=1 causes no state change.
